histogram_equalizer_lut: RTL and testbench



---
 rtl/histogram_equalizer_lut.sv | 138 +++++++++++++
 tb/tb_histogram_equalizer_lut.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/histogram_equalizer_lut.sv
// Post-frame histogram equalization: sweeps the histogram, builds the CDF,
// writes one 8-bit mapping per grey level into the LUT, then clears the histogram.
module histogram_equalizer_lut #(
  parameter int PIXEL_COUNT = 307200
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  output logic        oBusy,
  output logic        oDone,
  output logic [7:0]  oHistAddr,
  input  logic [19:0] iHistData,
  output logic [7:0]  oLutAddr,
  output logic [7:0]  oLutData,
  output logic        oLutWe,
  output logic        oClearRam
);

  typedef enum logic [2:0] {IDLE, READ, ACC, DIV, WRITE, CLEAR} stateT;

  localparam logic [19:0] PIX     = 20'(PIXEL_COUNT);
  localparam logic [19:0] CDF_MAX = '1;

  stateT       state;
  logic [19:0] cdf, cdfMin, denom, rem;
  logic        found;
  logic [7:0]  bin, divLow, clrCnt;
  logic [6:0]  quot;
  logic [2:0]  divCnt;

  logic [20:0] sum;
  logic [19:0] cdfNext, cdfMinNext, denomNext, diff, numNext, remSub, remNext;
  logic        foundNext, qBit;
  logic [27:0] dividend;
  logic [20:0] trial;
  logic [7:0]  qNext;

  // Next-state values for the ACC step, then one restoring-division step.
  always_comb begin
    sum        = {1'b0, cdf} + {1'b0, iHistData};
    cdfNext    = sum[20] ? CDF_MAX : sum[19:0];
    foundNext  = found | (iHistData != '0);
    cdfMinNext = (!found && iHistData != '0) ? iHistData : cdfMin;
    denomNext  = PIX - cdfMinNext;
    diff       = cdfNext - cdfMinNext;
    numNext    = '0;
    if (foundNext) numNext = (diff > denomNext) ? denomNext : diff;
    // num*255 = (num<<8) - num; quotient fits 8 bits since num <= denom
    dividend   = ({8'b0, numNext} << 8) - {8'b0, numNext} + {8'b0, 20'(denomNext >> 1)};

    trial   = {rem, divLow[7]};
    qBit    = trial >= {1'b0, denom};
    remSub  = {rem[18:0], divLow[7]} - denom;
    remNext = qBit ? remSub : trial[19:0];
    qNext   = {quot, qBit};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      cdf       <= '0;
      cdfMin    <= '0;
      found     <= 1'b0;
      bin       <= '0;
      denom     <= '0;
      rem       <= '0;
      divLow    <= '0;
      quot      <= '0;
      divCnt    <= '0;
      clrCnt    <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oHistAddr <= '0;
      oLutAddr  <= '0;
      oLutData  <= '0;
      oLutWe    <= 1'b0;
      oClearRam <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oLutWe <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          state     <= READ;
          bin       <= '0;
          cdf       <= '0;
          cdfMin    <= '0;
          found     <= 1'b0;
          oBusy     <= 1'b1;
          oHistAddr <= '0;
        end
        READ: state <= ACC;
        ACC: begin
          cdf    <= cdfNext;
          cdfMin <= cdfMinNext;
          found  <= foundNext;
          denom  <= denomNext;
          rem    <= dividend[27:8];
          divLow <= dividend[7:0];
          divCnt <= '0;
          state  <= DIV;
        end
        DIV: begin
          rem    <= remNext;
          divLow <= {divLow[6:0], 1'b0};
          quot   <= qNext[6:0];
          divCnt <= divCnt + 3'd1;
          if (divCnt == 3'd7) begin
            state    <= WRITE;
            oLutWe   <= 1'b1;
            oLutAddr <= bin;
            oLutData <= (denom == '0) ? bin : qNext;
          end
        end
        WRITE: if (bin == 8'd255) begin
          state     <= CLEAR;
          oClearRam <= 1'b1;
          clrCnt    <= '0;
        end else begin
          bin       <= bin + 8'd1;
          oHistAddr <= bin + 8'd1;
          state     <= READ;
        end
        CLEAR: if (clrCnt == 8'd255) begin
          state     <= IDLE;
          oClearRam <= 1'b0;
          oBusy     <= 1'b0;
          oDone     <= 1'b1;
        end else begin
          clrCnt <= clrCnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// Scoreboard bench: expected LUT writes are queued per run and popped as oLutWe pulses appear.
module tb_histogram_equalizer_lut;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iStart = 1'b0;
  logic        oBusy, oDone, oLutWe, oClearRam;
  logic [7:0]  oHistAddr, oLutAddr, oLutData;
  logic [19:0] iHistData = '0;

  logic [19:0] histMem [256];

  typedef struct {int addr; int data; int cyc;} expT;
  expT sb[$];

  int nCompared = 0;
  int nMismatched = 0;

  histogram_equalizer_lut dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
    .oHistAddr(oHistAddr), .iHistData(iHistData), .oLutAddr(oLutAddr),
    .oLutData(oLutData), .oLutWe(oLutWe), .oClearRam(oClearRam)
  );

  always #5 iClk = ~iClk;

  // Histogram RAM with one cycle read latency
  always @(posedge iClk) iHistData <= histMem[oHistAddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic setHist(input int mode);
    for (int b = 0; b < 256; b++) begin
      case (mode)
        0: histMem[b] = 20'd1200;
        1: histMem[b] = (b == 100) ? 20'd307200 : 20'd0;
        2: histMem[b] = (b == 10 || b == 200) ? 20'd153600 : 20'd0;
        3: histMem[b] = (b == 0 || b == 255) ? 20'd300000 : 20'd0;
        default: histMem[b] = (b < 2) ? 20'd700000 : 20'd0;
      endcase
    end
  endtask

  // Reference equalization with true division and saturating CDF
  task automatic pushExpected();
    longint cdf, cdfMin, denom, num, q;
    bit found;
    cdf = 0; cdfMin = 0; found = 0;
    for (int b = 0; b < 256; b++) begin
      cdf += longint'(histMem[b]);
      if (cdf > 1048575) cdf = 1048575;
      if (!found && histMem[b] != 0) begin
        cdfMin = longint'(histMem[b]);
        found = 1;
      end
      denom = (307200 - cdfMin) & 64'hFFFFF;
      num = 0;
      if (found) num = ((cdf - cdfMin) < denom) ? (cdf - cdfMin) : denom;
      q = (denom == 0) ? longint'(b) : (num * 255 + denom / 2) / denom;
      sb.push_back('{addr: b, data: int'(q), cyc: 11 + 11 * b});
    end
  endtask

  task automatic runFrame(input string name, input int pulseAt, input int rstAt);
    int cyc, doneCyc, weCnt, clrCnt, clrFirst, clrLast, doneSeen;
    expT e;
    pushExpected();
    @(negedge iClk);
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    cyc = 1; doneCyc = -1; weCnt = 0; clrCnt = 0; clrFirst = -1; clrLast = -1;
    check({name, "_busy_c1"}, oBusy, 1);
    while (cyc <= 3300) begin
      if (cyc % 11 == 1 && cyc <= 2806) check({name, "_hist_addr"}, oHistAddr, (cyc - 1) / 11);
      if (cyc == 3072) check({name, "_busy_c3072"}, oBusy, 1);
      if (oLutWe) begin
        weCnt++;
        if (sb.size() == 0) check({name, "_extra_write"}, cyc, 0);
        else begin
          e = sb.pop_front();
          check({name, "_lut_addr"}, oLutAddr, e.addr);
          check({name, "_lut_data"}, oLutData, e.data);
          check({name, "_lut_cycle"}, cyc, e.cyc);
        end
      end
      if (oClearRam) begin
        clrCnt++;
        if (clrFirst < 0) clrFirst = cyc;
        clrLast = cyc;
      end
      if (oDone) begin
        doneCyc = cyc;
        break;
      end
      if (rstAt != 0 && cyc == rstAt) begin
        iRst = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        check({name, "_rst_busy"}, oBusy, 0);
        check({name, "_rst_we"}, oLutWe, 0);
        check({name, "_rst_clear"}, oClearRam, 0);
        doneSeen = 0; weCnt = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge iClk);
          @(negedge iClk);
          if (oDone) doneSeen++;
          if (oLutWe || oClearRam || oBusy) weCnt++;
        end
        check({name, "_rst_no_done"}, doneSeen, 0);
        check({name, "_rst_quiet"}, weCnt, 0);
        sb.delete();
        return;
      end
      iStart = (cyc == pulseAt);
      @(posedge iClk);
      @(negedge iClk);
      cyc++;
    end
    iStart = 1'b0;
    check({name, "_done_cycle"}, doneCyc, 3073);
    check({name, "_done_not_busy"}, oBusy, 0);
    check({name, "_we_count"}, weCnt, 256);
    check({name, "_clear_count"}, clrCnt, 256);
    check({name, "_clear_first"}, clrFirst, 2817);
    check({name, "_clear_last"}, clrLast, 3072);
    check({name, "_sb_left"}, sb.size(), 0);
    sb.delete();
    @(posedge iClk);
    @(negedge iClk);
    check({name, "_done_pulse"}, oDone, 0);
  endtask

  initial begin
    setHist(0);
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_we", oLutWe, 0);
    check("rst_clear", oClearRam, 0);
    check("rst_hist_addr", oHistAddr, 0);
    check("rst_lut_addr", oLutAddr, 0);
    check("rst_lut_data", oLutData, 0);
    iRst = 1'b0;
    repeat (2) @(posedge iClk);

    setHist(0); runFrame("uniform", 0, 0);
    setHist(1); runFrame("single_bin", 0, 0);
    setHist(2); runFrame("two_bins", 0, 0);
    setHist(3); runFrame("overfull", 0, 0);
    setHist(4); runFrame("saturate", 0, 0);
    setHist(0); runFrame("restart_ignored", 500, 0);
    setHist(2); runFrame("mid_reset", 0, 1000);
    setHist(0); runFrame("after_reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
